// File: rtl/mash_dac_pkg.sv
// Shared widths, limits and helpers for the MASH 1-1-1 delta-sigma DAC.
package mash_dac_pkg;

   localparam int unsigned IN_W = 16;
   localparam int unsigned Y_W  = 4;
   localparam int unsigned R_W  = 6;
   localparam int          R_MAX = 31;
   localparam int          R_MIN = -32;

   // Combiner output level, -3..+4 in two's complement
   typedef logic signed [Y_W-1:0] level_t;
   // Requantizer error residue
   typedef logic signed [R_W-1:0] resid_t;

   function automatic level_t to_level(input logic b);
      return level_t'({{(Y_W-1){1'b0}}, b});
   endfunction

   function automatic resid_t sat_resid(input logic signed [R_W:0] v);
      int vi;
      vi = int'(v);
      if (vi > R_MAX) return resid_t'(R_MAX);
      if (vi < R_MIN) return resid_t'(R_MIN);
      return v[R_W-1:0];
   endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One first-order accumulator stage: registered sum, combinational next sum and carry.
module mash_acc_stage
   import mash_dac_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] addend,
   output logic [IN_W-1:0] sum,
   output logic            carry
);

   logic [IN_W-1:0] acc_q;

   assign {carry, sum} = {1'b0, acc_q} + {1'b0, addend};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= sum;
   end

endmodule

// File: rtl/mash_dac.sv
// Third-order MASH 1-1-1 delta-sigma DAC: three chained accumulators, noise-cancelling
// combiner and a first-order error-feedback 1-bit requantizer.
module mash_dac
   import mash_dac_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] in,
   output logic            out
);

   logic [IN_W-1:0] sum1, sum2, sum3;
   logic            c1, c2, c3;
   logic            c1_q, c2_q, c3_q;
   logic            c2_d1_q, c3_d1_q, c3_d2_q;
   level_t          y_d, y_q;
   resid_t          r_q, r_d;
   logic signed [R_W:0] t;
   logic            out_d, out_q;

   // Each stage integrates the same-cycle sum of the previous one
   mash_acc_stage u_stage1 (.clk(clk), .rst(rst), .addend(in),   .sum(sum1), .carry(c1));
   mash_acc_stage u_stage2 (.clk(clk), .rst(rst), .addend(sum1), .sum(sum2), .carry(c2));
   mash_acc_stage u_stage3 (.clk(clk), .rst(rst), .addend(sum2), .sum(sum3), .carry(c3));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c1_q    <= 1'b0;
         c2_q    <= 1'b0;
         c3_q    <= 1'b0;
         c2_d1_q <= 1'b0;
         c3_d1_q <= 1'b0;
         c3_d2_q <= 1'b0;
         y_q     <= '0;
         r_q     <= '0;
         out_q   <= 1'b0;
      end else begin
         c1_q    <= c1;
         c2_q    <= c2;
         c3_q    <= c3;
         c2_d1_q <= c2_q;
         c3_d1_q <= c3_q;
         c3_d2_q <= c3_d1_q;
         y_q     <= y_d;
         r_q     <= r_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      // y = c1 + (1 - z^-1) c2 + (1 - z^-1)^2 c3
      y_d = to_level(c1_q)
          + to_level(c2_q) - to_level(c2_d1_q)
          + to_level(c3_q) - (to_level(c3_d1_q) <<< 1) + to_level(c3_d2_q);
      t     = {r_q[R_W-1], r_q} + {{(R_W+1-Y_W){y_q[Y_W-1]}}, y_q};
      out_d = !t[R_W] && (t != '0);
      r_d   = sat_resid(t - {{R_W{1'b0}}, out_d});
   end

   assign out = out_q;

   logic unused_sum3;
   assign unused_sum3 = ^sum3;

endmodule

// File: tb/tb_mash_dac.sv
// Directed self-checking bench for mash_dac.
module tb_mash_dac;

   logic        clk;
   logic        rst;
   logic [15:0] in;
   logic        out;

   int n_checks;
   int n_pass;

   mash_dac dut (.clk(clk), .rst(rst), .in(in), .out(out));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset for a few cycles, then release mid-cycle with a new code applied
   task automatic do_reset(input logic [15:0] code);
      rst = 1'b1;
      repeat (5) tick();
      in  = code;
      rst = 1'b0;
   endtask

   task automatic count_ones(input int n, output int ones);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (out === 1'b1) ones++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in  = 16'hFFFF;
      repeat (5) tick();
      n_checks++;
      if (out !== 1'b0) $display("FAIL reset_state: out=%b required 0", out);
      else n_pass++;
   endtask

   task automatic test_zero();
      int ones;
      do_reset(16'd0);
      count_ones(2000, ones);
      n_checks++;
      if (ones !== 0) $display("FAIL zero_input: ones=%0d required 0", ones);
      else n_pass++;
   endtask

   // For in=0x8000 out is 0 on edges 1..3, then 1 on even edges and 0 on odd edges
   task automatic check_half_seq(input string tag);
      logic exp;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp = (k >= 4) && (k % 2 == 0);
         n_checks++;
         if (out !== exp) $display("FAIL %s edge%0d: out=%b required %b", tag, k, out, exp);
         else n_pass++;
      end
   endtask

   task automatic test_half_exact();
      do_reset(16'd32768);
      check_half_seq("half_seq");
   endtask

   task automatic test_near_half();
      int ones;
      do_reset(16'd32767);
      repeat (1000) tick();
      count_ones(16384, ones);   // ideal 8191.75
      n_checks++;
      if (ones < 8184 || ones > 8199)
         $display("FAIL mean_32767: ones=%0d required 8184..8199", ones);
      else n_pass++;
   endtask

   task automatic test_full_scale();
      int ones;
      int run;
      int max_run;
      do_reset(16'd65535);
      repeat (64) tick();
      ones    = 0;
      run     = 0;
      max_run = 0;
      for (int i = 0; i < 8192; i++) begin
         tick();
         if (out === 1'b1) begin
            ones++;
            run = 0;
         end else begin
            run++;
            if (run > max_run) max_run = run;
         end
      end
      n_checks++;
      if (ones < 8184 || ones > 8192)
         $display("FAIL mean_65535: ones=%0d required 8184..8192", ones);
      else n_pass++;
      n_checks++;
      if (max_run > 1) $display("FAIL zero_run_65535: run=%0d required <=1", max_run);
      else n_pass++;
   endtask

   task automatic test_quarter_windows();
      int ones;
      do_reset(16'd16384);
      repeat (64) tick();
      for (int w = 0; w < 4; w++) begin
         count_ones(1024, ones);
         n_checks++;
         if (ones < 250 || ones > 262)
            $display("FAIL window_16384_%0d: ones=%0d required 250..262", w, ones);
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      int  guard;
      do_reset(16'd57344);
      repeat (37) tick();
      guard = 0;
      while (out !== 1'b1 && guard < 64) begin
         tick();
         guard++;
      end
      n_checks++;
      if (out !== 1'b1) $display("FAIL pre_reset_out: out=%b required 1", out);
      else n_pass++;
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if (out !== 1'b0) $display("FAIL async_reset: out=%b required 0", out);
      else n_pass++;
      repeat (3) tick();
      in  = 16'd32768;
      rst = 1'b0;
      check_half_seq("restart_seq");
   endtask

   task automatic track_r(inout int rmin, inout int rmax);
      int rv;
      rv = int'($signed(dut.r_q));
      if (rv < rmin) rmin = rv;
      if (rv > rmax) rmax = rv;
   endtask

   task automatic test_step();
      int ones;
      int rmin;
      int rmax;
      rmin = 0;
      rmax = 0;
      do_reset(16'd8192);
      for (int i = 0; i < 64; i++) begin
         tick();
         track_r(rmin, rmax);
      end
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         tick();
         track_r(rmin, rmax);
         if (out === 1'b1) ones++;
      end
      n_checks++;
      if (ones < 122 || ones > 134) $display("FAIL step_low: ones=%0d required 122..134", ones);
      else n_pass++;
      in = 16'd57344;
      for (int i = 0; i < 64; i++) begin
         tick();
         track_r(rmin, rmax);
      end
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         tick();
         track_r(rmin, rmax);
         if (out === 1'b1) ones++;
      end
      n_checks++;
      if (ones < 890 || ones > 902) $display("FAIL step_high: ones=%0d required 890..902", ones);
      else n_pass++;
      n_checks++;
      if (rmin < -8 || rmax > 8)
         $display("FAIL residue_range: min=%0d max=%0d required -8..8", rmin, rmax);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      in       = '0;
      test_reset();
      test_zero();
      test_half_exact();
      test_near_half();
      test_full_scale();
      test_quarter_windows();
      test_mid_reset();
      test_step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mash_dac.md
# mash_dac

Third-order MASH 1-1-1 delta-sigma DAC core with a 1-bit output. It takes a 16-bit unsigned code and produces a noise-shaped single-bit stream whose long-term mean equals in/65536. The block sits between a digital sample source and an external 1-bit reconstruction path (RC filter or pad driver), and runs at the oversampling clock.

## Interface
- No parameters. Input width is 16 and accumulator width is 16, both fixed.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  16  unsigned code; the target duty is in/65536. It is sampled every clock and need not be held.
- out  output  1  delta-sigma bitstream, registered.

## Operation
- Stage 1: s1 = a1 + in (17 bits); c1 = s1[16]; a1_next = s1[15:0].
- Stage 2: s2 = a2 + a1_next; c2 = carry; a2_next = s2[15:0]. Stage 2 uses the same-cycle stage-1 sum.
- Stage 3: s3 = a3 + a2_next; c3 = carry; a3_next = s3[15:0].
- Noise-cancellation combiner, signed: y = c1 + (c2 − c2_d1) + (c3 − 2·c3_d1 + c3_d2).
  - c2_d1, c3_d1 and c3_d2 are the carries from previous clocks.
  - y spans −3..+4; hold it as 4-bit two's complement.
- 1-bit requantizer (first-order error feedback):
  - t = r + y_reg.
  - out_next = (t ≥ 1).
  - r_next = t − out_next.
  - r is a 6-bit signed register that saturates at −32/+31. In normal operation r never approaches those limits.
- The long-term mean of out equals in/65536 exactly; the maximum is 65535/65536.
- in = 0 yields out held at 0 permanently.
- All accumulator arithmetic wraps modulo 2^16, and the carry is the overflow bit.

## Timing
- Reset clears a1, a2, a3, every carry delay, y_reg, r and out to 0, immediately and asynchronously.
- A reset asserted mid-stream restarts the modulator from zero state. There is no partial state and no glitch on out beyond the forced 0.
- Pipeline:
  - Edge 1: in enters the stage chain and the carries are registered.
  - Edge 2: y_reg updates.
  - Edge 3: out updates.
- Latency from an in change to its first effect on out is 3 clocks.
- The first clock after reset release already accumulates in.
- A step change of in has no settling constraint; the mean tracks the new value after the carry delay line (2 clocks) flushes.

## Structure
- Shared package mash_dac_pkg:
  - IN_W = 16.
  - Y_W = 4.
  - R_W = 6.
  - R_MAX = 31 and R_MIN = −32.
  - A typedef for the signed combiner level.
- Sub-module mash_acc_stage, instantiated 3 times:
  - Registered 16-bit accumulator.
  - Inputs: addend, clk, rst.
  - Outputs: combinational next sum and carry.
- The top level holds the carry delays, the combiner and the requantizer.

## Test plan
- in = 0, reset for 5 cycles then released → out = 0 on every cycle for 100000 cycles.
- in = 32767 → after 1000 settling cycles, the mean of out over 100000 cycles is 0.49998 ± 0.0001.
- in = 65535 → mean over 100000 cycles is 0.99998 ± 0.0001; out is never 0 for more than 1 consecutive cycle after settling.
- in = 16384 → mean is 0.25 ± 0.0001; the mean over each 1024-cycle window is within ±0.01.
- Mid-run reset → asserting rst at an arbitrary cycle forces out = 0 asynchronously. After release with in = 32768, the out sequence is bit-identical to a fresh run from reset.
- Step from in = 8192 to in = 57344 → the windowed mean moves from 0.125 to 0.875 within 4096 cycles; r stays within −8..+8 throughout, and saturation is never hit.
